// File: rtl/inst_sram_slave_pkg.sv
// Shared configuration for the instruction SRAM slave: bus widths, counter width
// and the fetch-response FSM encoding.
package inst_sram_slave_pkg;

    localparam int unsigned XLEN_BUS = 64;
    localparam int unsigned INST_LEN = 32;

    // LATENCY is limited to 0..7, so three bits cover the wait counter.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_sram_slave_if.sv
// Fetch request/response and backdoor-load bundle between the fetch stage (master)
// and the instruction SRAM slave.
interface inst_sram_slave_if #(
    parameter int unsigned XLEN     = inst_sram_slave_pkg::XLEN_BUS,
    parameter int unsigned INST_LEN = inst_sram_slave_pkg::INST_LEN
);

    logic                req_valid;
    logic                req_ready;
    logic [XLEN-1:0]     req_addr;
    logic                flush;
    logic                resp_valid;
    logic                resp_ready;
    logic [INST_LEN-1:0] resp_data;
    logic                resp_err;
    logic                ld_en;
    logic [XLEN-1:0]     ld_addr;
    logic [INST_LEN-1:0] ld_data;

    modport master (
        output req_valid, req_addr, flush, resp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/inst_sram_slave_imem_array.sv
// DEPTH x INST_LEN instruction store with one synchronous read port and one write port.
// Contents are never reset.
module inst_sram_slave_imem_array #(
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned INST_LEN = 32,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_idx,
    output logic [INST_LEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [INST_LEN-1:0] wr_data
);

    logic [INST_LEN-1:0] mem_q [DEPTH];
    logic [INST_LEN-1:0] rd_data_q;

    // Read and write share one edge, so a same-word collision returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_sram_slave.sv
// Instruction SRAM responder for the fetch stage: one outstanding request, programmable
// wait latency, range/alignment checking and a backdoor load port.
module inst_sram_slave #(
    parameter int unsigned    XLEN      = inst_sram_slave_pkg::XLEN_BUS,
    parameter int unsigned    INST_LEN  = inst_sram_slave_pkg::INST_LEN,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(64'h8000_0000),
    parameter int unsigned    DEPTH     = 4096,
    parameter int unsigned    LATENCY   = 1
) (
    input  logic               clk,
    input  logic               rst,
    inst_sram_slave_if.slave   bus
);

    import inst_sram_slave_pkg::*;

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CntInit = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [XLEN-1:0]  EndAddr = BASE_ADDR + XLEN'(4 * DEPTH);

    function automatic logic addr_bad(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (a >= EndAddr);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    fetch_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                err_q, err_d;

    logic                req_bad;
    logic                rd_en;
    logic [AW-1:0]       rd_idx;
    logic [INST_LEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_idx;

    assign req_bad = addr_bad(bus.req_addr);
    assign wr_en   = bus.ld_en && !addr_bad(bus.ld_addr);
    assign wr_idx  = word_idx(bus.ld_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // The array read is issued on whichever edge enters StResp, so data lines up with
    // resp_valid; errored requests never touch the array.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && !bus.flush) begin
                    idx_d = word_idx(bus.req_addr);
                    err_d = req_bad;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        rd_en   = !req_bad;
                        rd_idx  = idx_d;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StResp;
                    rd_en   = !err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                // Flush and handshake both return to idle; flush wins, nothing else differs.
                if (bus.flush || bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == StIdle) && !bus.flush;
        bus.resp_valid = (state_q == StResp);
        bus.resp_err   = (state_q == StResp) && err_q;
        bus.resp_data  = ((state_q == StResp) && !err_q) ? rd_data : '0;
    end

    inst_sram_slave_imem_array #(
        .DEPTH    (DEPTH),
        .INST_LEN (INST_LEN),
        .AW       (AW)
    ) u_imem_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (bus.ld_data)
    );

endmodule

// File: tb/tb_inst_sram_slave.sv
// Directed bench for inst_sram_slave: three instances (LATENCY 0, 1, 7) share one stimulus
// set; detailed checks run against LATENCY=1, latency/throughput checks against all three.
module tb_inst_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, flush, resp_ready, ld_en;
    logic [63:0] req_addr, ld_addr;
    logic [31:0] ld_data;
    logic        mon_clr;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_sram_slave_if #(.XLEN(64), .INST_LEN(32)) bus0 ();
    inst_sram_slave_if #(.XLEN(64), .INST_LEN(32)) bus1 ();
    inst_sram_slave_if #(.XLEN(64), .INST_LEN(32)) bus7 ();

    assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
    assign bus7.req_valid = req_valid;  assign bus0.req_addr = req_addr;
    assign bus1.req_addr = req_addr;    assign bus7.req_addr = req_addr;
    assign bus0.flush = flush;          assign bus1.flush = flush;
    assign bus7.flush = flush;          assign bus0.resp_ready = resp_ready;
    assign bus1.resp_ready = resp_ready; assign bus7.resp_ready = resp_ready;
    assign bus0.ld_en = ld_en;          assign bus1.ld_en = ld_en;
    assign bus7.ld_en = ld_en;          assign bus0.ld_addr = ld_addr;
    assign bus1.ld_addr = ld_addr;      assign bus7.ld_addr = ld_addr;
    assign bus0.ld_data = ld_data;      assign bus1.ld_data = ld_data;
    assign bus7.ld_data = ld_data;

    inst_sram_slave #(.LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    inst_sram_slave #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    inst_sram_slave #(.LATENCY(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

    // Per-instance log of accept-to-response distance, accept spacing and returned data.
    int cyc_n = 0;
    int acc0 = -1, acc1 = -1, acc7 = -1;
    int lat0_q[$], lat1_q[$], lat7_q[$];
    int gap0_q[$], gap1_q[$], gap7_q[$];
    logic [31:0] dat0_q[$], dat1_q[$], dat7_q[$];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (mon_clr) begin
            lat0_q.delete(); lat1_q.delete(); lat7_q.delete();
            gap0_q.delete(); gap1_q.delete(); gap7_q.delete();
            dat0_q.delete(); dat1_q.delete(); dat7_q.delete();
            acc0 <= -1; acc1 <= -1; acc7 <= -1;
        end else begin
            if (bus0.req_valid && bus0.req_ready) begin
                if (acc0 >= 0) gap0_q.push_back(cyc_n - acc0);
                acc0 <= cyc_n;
            end
            if (bus0.resp_valid) begin lat0_q.push_back(cyc_n - acc0); dat0_q.push_back(bus0.resp_data); end
            if (bus1.req_valid && bus1.req_ready) begin
                if (acc1 >= 0) gap1_q.push_back(cyc_n - acc1);
                acc1 <= cyc_n;
            end
            if (bus1.resp_valid) begin lat1_q.push_back(cyc_n - acc1); dat1_q.push_back(bus1.resp_data); end
            if (bus7.req_valid && bus7.req_ready) begin
                if (acc7 >= 0) gap7_q.push_back(cyc_n - acc7);
                acc7 <= cyc_n;
            end
            if (bus7.resp_valid) begin lat7_q.push_back(cyc_n - acc7); dat7_q.push_back(bus7.resp_data); end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc();
        ld_en = 1'b0;
    endtask

    // One LATENCY=1 transaction with resp_ready high; reports what the DUT did.
    task automatic fetch(input logic [63:0] addr, output logic rdy, output int lat,
                         output logic [31:0] data, output logic err);
        req_valid = 1'b1; req_addr = addr; resp_ready = 1'b1; flush = 1'b0;
        #1 rdy = bus1.req_ready;
        cyc();
        req_valid = 1'b0;
        lat = 99; data = '0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (bus1.resp_valid) begin
                lat = n; data = bus1.resp_data; err = bus1.resp_err;
                break;
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_reset();
        #1;
        n_run++; if (bus1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus1.resp_valid); end
        n_run++; if (bus1.resp_data !== 32'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", bus1.resp_data); end
        n_run++; if (bus1.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", bus1.resp_err); end
        n_run++; if (u_dut7.cnt_q !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", u_dut7.cnt_q); end
        cyc();
        rst = 1'b0;
        #1;
        n_run++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus1.req_ready); end
        cyc();
    endtask

    task automatic test_basic();
        logic rdy; int lat; logic [31:0] d; logic e;
        fetch(64'h8000_0000, rdy, lat, d, e);
        n_run++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", rdy); end
        n_run++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
        n_run++; if (d !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_data: got %h want 00000013", d); end
        n_run++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", e); end
        fetch(64'h8000_0004, rdy, lat, d, e);
        n_run++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word1_data: got %h want deadbeef", d); end
        fetch(64'h8000_3FFC, rdy, lat, d, e);
        n_run++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL last_word_data: got %h want 12345678", d); end
        n_run++; if (e !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b want 0", e); end
    endtask

    task automatic test_errors();
        logic rdy; int lat; logic [31:0] d; logic e;
        fetch(64'h8000_0002, rdy, lat, d, e);
        n_run++; if (lat != 2) begin n_fail++; $display("FAIL misalign_latency: got %0d want 2", lat); end
        n_run++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", e); end
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL misalign_data: got %h want 0", d); end
        fetch(64'h8000_4000, rdy, lat, d, e);
        n_run++; if (e !== 1'b1) begin n_fail++; $display("FAIL above_range_err: got %b want 1", e); end
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL above_range_data: got %h want 0", d); end
        fetch(64'h7FFF_FFFC, rdy, lat, d, e);
        n_run++; if (e !== 1'b1) begin n_fail++; $display("FAIL below_range_err: got %b want 1", e); end
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL below_range_data: got %h want 0", d); end
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_addr = 64'h8000_0004; resp_ready = 1'b0; flush = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_run++; if (bus1.resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus1.resp_valid); end
            n_run++; if (bus1.resp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want deadbeef", i, bus1.resp_data); end
            n_run++; if (bus1.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, bus1.req_ready); end
            cyc();
        end
        resp_ready = 1'b1;
        #1;
        n_run++; if (bus1.resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b want 1", bus1.resp_valid); end
        cyc();
        #1;
        n_run++; if (bus1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after_valid: got %b want 0", bus1.resp_valid); end
        n_run++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_after_ready: got %b want 1", bus1.req_ready); end
        cyc();
    endtask

    task automatic test_flush();
        logic rdy; int lat; logic [31:0] d; logic e; logic seen;
        // flush while waiting
        req_valid = 1'b1; req_addr = 64'h8000_0000; resp_ready = 1'b1; flush = 1'b0;
        cyc();
        req_valid = 1'b0; flush = 1'b1;
        #1;
        n_run++; if (bus1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_valid: got %b want 0", bus1.resp_valid); end
        cyc();
        flush = 1'b0;
        #1;
        n_run++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wait_idle: got %b want 1", bus1.req_ready); end
        seen = 1'b0;
        repeat (3) begin
            if (bus1.resp_valid) seen = 1'b1;
            cyc(); #1;
        end
        n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_wait_noresp: got %b want 0", seen); end
        cyc();
        fetch(64'h8000_0000, rdy, lat, d, e);
        n_run++; if (lat != 2 || d !== 32'h13) begin n_fail++; $display("FAIL flush_wait_next: got lat %0d data %h want 2 00000013", lat, d); end
        // flush in the response cycle together with resp_ready
        req_valid = 1'b1; req_addr = 64'h8000_0004;
        cyc();
        req_valid = 1'b0;
        cyc();
        #1;
        n_run++; if (bus1.resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_resp_pre: got %b want 1", bus1.resp_valid); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        n_run++; if (bus1.resp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resp_idle: got valid %b ready %b want 0 1", bus1.resp_valid, bus1.req_ready); end
        cyc();
        fetch(64'h8000_0000, rdy, lat, d, e);
        n_run++; if (lat != 2 || d !== 32'h13) begin n_fail++; $display("FAIL flush_resp_next: got lat %0d data %h want 2 00000013", lat, d); end
        // flush in idle blocks a simultaneous request
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0000;
        #1;
        n_run++; if (bus1.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready: got %b want 0", bus1.req_ready); end
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            #1; if (bus1.resp_valid) seen = 1'b1;
            cyc();
        end
        n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_idle_noaccept: got %b want 0", seen); end
    endtask

    task automatic test_load();
        logic rdy; int lat; logic [31:0] d; logic e;
        // write to the word being read on the edge that enters the response state
        req_valid = 1'b1; req_addr = 64'h8000_0008; resp_ready = 1'b1; flush = 1'b0;
        cyc();
        req_valid = 1'b0; ld_en = 1'b1; ld_addr = 64'h8000_0008; ld_data = 32'h2222_2222;
        cyc();
        ld_en = 1'b0;
        #1;
        n_run++; if (bus1.resp_valid !== 1'b1) begin n_fail++; $display("FAIL collide_valid: got %b want 1", bus1.resp_valid); end
        n_run++; if (bus1.resp_data !== 32'h1111_1111) begin n_fail++; $display("FAIL collide_old_data: got %h want 11111111", bus1.resp_data); end
        cyc();
        fetch(64'h8000_0008, rdy, lat, d, e);
        n_run++; if (d !== 32'h2222_2222) begin n_fail++; $display("FAIL collide_new_data: got %h want 22222222", d); end
        // illegal load addresses must leave the array untouched
        load(64'h8000_0002, 32'hFFFF_FFFF);
        load(64'h8000_4000, 32'hEEEE_EEEE);
        load(64'h7FFF_FFFC, 32'hDDDD_DDDD);
        fetch(64'h8000_0000, rdy, lat, d, e);
        n_run++; if (d !== 32'h0000_0013) begin n_fail++; $display("FAIL ld_ignored_word0: got %h want 00000013", d); end
        fetch(64'h8000_3FFC, rdy, lat, d, e);
        n_run++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_ignored_last: got %h want 12345678", d); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        req_valid = 1'b1; req_addr = 64'h8000_0000; resp_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        #1;
        n_run++; if (u_dut7.cnt_q !== 3'd6) begin n_fail++; $display("FAIL wait_cnt_load: got %0d want 6", u_dut7.cnt_q); end
        rst = 1'b1;
        #1;
        n_run++; if (bus1.resp_valid !== 1'b0 || bus1.resp_data !== 32'h0 || bus1.resp_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b %h %b want 0 0 0", bus1.resp_valid, bus1.resp_data, bus1.resp_err);
        end
        n_run++; if (u_dut7.cnt_q !== 3'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", u_dut7.cnt_q); end
        cyc();
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            #1; if (bus0.resp_valid || bus1.resp_valid || bus7.resp_valid) seen = 1'b1;
            cyc();
        end
        n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_noresp: got %b want 0", seen); end
        #1;
        n_run++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus1.req_ready); end
        cyc();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; cyc(); rst = 1'b0;
        mon_clr = 1'b1; cyc(); mon_clr = 1'b0;
        req_valid = 1'b1; req_addr = 64'h8000_0000; resp_ready = 1'b1; flush = 1'b0;
        repeat (40) cyc();
        req_valid = 1'b0;
        repeat (12) cyc();
        // 40 request cycles: accepts every LATENCY+2 cycles
        n_run++; if (lat0_q.size() != 20) begin n_fail++; $display("FAIL b2b_count_lat0: got %0d want 20", lat0_q.size()); end
        n_run++; if (lat1_q.size() != 14) begin n_fail++; $display("FAIL b2b_count_lat1: got %0d want 14", lat1_q.size()); end
        n_run++; if (lat7_q.size() != 5) begin n_fail++; $display("FAIL b2b_count_lat7: got %0d want 5", lat7_q.size()); end
        foreach (lat0_q[i]) begin
            n_run++; if (lat0_q[i] != 1 || dat0_q[i] !== 32'h13) begin n_fail++; $display("FAIL b2b_lat0[%0d]: got %0d %h want 1 00000013", i, lat0_q[i], dat0_q[i]); end
        end
        foreach (lat1_q[i]) begin
            n_run++; if (lat1_q[i] != 2 || dat1_q[i] !== 32'h13) begin n_fail++; $display("FAIL b2b_lat1[%0d]: got %0d %h want 2 00000013", i, lat1_q[i], dat1_q[i]); end
        end
        foreach (lat7_q[i]) begin
            n_run++; if (lat7_q[i] != 8 || dat7_q[i] !== 32'h13) begin n_fail++; $display("FAIL b2b_lat7[%0d]: got %0d %h want 8 00000013", i, lat7_q[i], dat7_q[i]); end
        end
        foreach (gap0_q[i]) begin
            n_run++; if (gap0_q[i] != 2) begin n_fail++; $display("FAIL b2b_gap0[%0d]: got %0d want 2", i, gap0_q[i]); end
        end
        foreach (gap1_q[i]) begin
            n_run++; if (gap1_q[i] != 3) begin n_fail++; $display("FAIL b2b_gap1[%0d]: got %0d want 3", i, gap1_q[i]); end
        end
        foreach (gap7_q[i]) begin
            n_run++; if (gap7_q[i] != 9) begin n_fail++; $display("FAIL b2b_gap7[%0d]: got %0d want 9", i, gap7_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0; ld_en = 1'b0;
        req_addr = '0; ld_addr = '0; ld_data = '0; mon_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        load(64'h8000_0000, 32'h0000_0013);
        load(64'h8000_0004, 32'hDEAD_BEEF);
        load(64'h8000_0008, 32'h1111_1111);
        load(64'h8000_3FFC, 32'h1234_5678);
        test_basic();
        test_errors();
        test_stall();
        test_flush();
        test_load();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
